// File: rtl/spi_ram_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_ram_cmd_master
//
// SPI initiator for the single-port RAM command protocol. Each host request
// (op[1:0] + data[7:0]) is sent as a 10-bit frame, MSB first, on mosi while
// ss_n is low. For a read-data request (op = 2'b11) ss_n stays low through a
// fixed turnaround of RD_LAT cycles. The 8-bit RAM byte is then shifted in
// from miso, MSB first, and returned to the host as a single-cycle rsp_valid
// pulse. After every frame, ss_n is held high for GAP_CYCLES cycles.
//
// Parameters
//   RD_LAT      cycles between the last command bit and the first miso bit (1..16)
//   GAP_CYCLES  ss_n-high cycles enforced between frames (1..16)
//
// Ports
//   clk         clock; mosi/ss_n update and miso is sampled on posedge
//   rst_n       synchronous active-low reset
//   req_valid   host request present
//   req_ready   high only in IDLE (and not in reset); transfer = valid & ready
//   req_op      00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   req_data    address or data byte
//   rsp_valid   one-cycle pulse, rsp_data valid (read-data only)
//   rsp_data    byte read from miso; holds until the next rsp_valid
//   ss_n        slave select, active-low
//   mosi        serial command, MSB first
//   miso        serial read data, MSB first; ignored outside RECV
//   busy        high whenever the FSM is not in IDLE
//
// Optional feature: define SPI_MASTER_STATS_EN to add
//   frame_cnt   [15:0] +1 on each GAP entry (one per completed frame), wraps
//   rd_cnt      [15:0] +1 with each rsp_valid, wraps
// -----------------------------------------------------------------------------
module spi_ram_cmd_master #(
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        ss_n,
   output logic        mosi,
   input  logic        miso,
   output logic        busy
`ifdef SPI_MASTER_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] rd_cnt
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT,
      ST_RECV,
      ST_GAP
   } state_e;

   // Terminal counts of the 4-bit per-state counter (counter restarts at 0
   // on every state entry, so the last cycle of a state is N-1).
   localparam logic [3:0] SHIFT_LAST = 4'd9;
   localparam logic [3:0] RECV_LAST  = 4'd7;
   localparam logic [3:0] WAIT_LAST  = 4'(RD_LAT - 1);
   localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [9:0]  frame_q, frame_d;      // outgoing frame, bit 9 is on mosi
   logic        rd_op_q, rd_op_d;      // current frame is read-data
   logic [7:0]  rx_q, rx_d;            // miso shift register
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_valid_q, rsp_valid_d;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      rd_op_d     = rd_op_q;
      rx_d        = rx_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      req_ready   = 1'b0;
      busy        = 1'b1;
      ss_n        = 1'b0;
      mosi        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy      = 1'b0;
            ss_n      = 1'b1;
            // Not ready while reset is held, even though the state is IDLE.
            req_ready = rst_n;
            if (req_valid) begin
               frame_d = {req_op, req_data};
               rd_op_d = &req_op;
               cnt_d   = 4'd0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            mosi    = frame_q[9];
            frame_d = {frame_q[8:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == SHIFT_LAST) begin
               cnt_d   = 4'd0;
               state_d = rd_op_q ? ST_WAIT : ST_GAP;
            end
         end

         ST_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_RECV;
            end
         end

         ST_RECV: begin
            rx_d  = {rx_q[6:0], miso};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == RECV_LAST) begin
               // The 8th sample goes straight to the response register so
               // rsp_valid rises on the same edge that enters GAP.
               rsp_data_d  = {rx_q[6:0], miso};
               rsp_valid_d = 1'b1;
               cnt_d       = 4'd0;
               state_d     = ST_GAP;
            end
         end

         ST_GAP: begin
            ss_n  = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            ss_n    = 1'b1;
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: reset is sampled on the clock edge only; a mid-frame reset takes
   // effect at the next posedge and abandons the frame without a response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments keep every register updating from
         // the values seen before the edge, independent of statement order.
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         frame_q     <= 10'd0;
         rd_op_q     <= 1'b0;
         rx_q        <= 8'd0;
         rsp_data_q  <= 8'd0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         rd_op_q     <= rd_op_d;
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

`ifdef SPI_MASTER_STATS_EN
   // ---------------------------------------------------------------------------
   // Frame / read statistics (free-running, wrap at 16 bits)
   // ---------------------------------------------------------------------------
   logic [15:0] frame_cnt_q;
   logic [15:0] rd_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_q <= 16'd0;
         rd_cnt_q    <= 16'd0;
      end else begin
         if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (rsp_valid_d) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign rd_cnt    = rd_cnt_q;
`endif

endmodule
